// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory target with programmable wait states
// Optional feature: define DMEM_MISALIGN_ERR_EN to report misaligned H/HU/W accesses as errors.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  size,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        hs, enter_resp;

    logic [31:0] addr_q, wdata_q;
    logic [2:0]  size_q;
    logic        wr_q, rd_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] a_addr, a_wdata, word, ld, wd;
    logic [2:0]  a_size;
    logic        a_wr, a_rd, size_ok, oob, misalign, acc_err;
    logic [29:0] idx;
    logic [3:0]  be;

    assign hs = (state == IDLE) && req_valid && (rd_en || wr_en);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        enter_resp = 1'b0;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                req_ready = !reset;
                busy      = 1'b0;
                if (hs) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt  = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt  = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // With zero wait states the access happens on the acceptance edge, so use live inputs.
    always_comb begin
        a_addr  = (state == IDLE) ? addr  : addr_q;
        a_wdata = (state == IDLE) ? wdata : wdata_q;
        a_size  = (state == IDLE) ? size  : size_q;
        a_wr    = (state == IDLE) ? wr_en : wr_q;
        a_rd    = (state == IDLE) ? rd_en : rd_q;
        idx     = a_addr[31:2];
        word    = mem[idx[AW-1:0]];
        size_ok = (a_size == 3'b000) || (a_size == 3'b001) || (a_size == 3'b010) ||
                  (a_size == 3'b100) || (a_size == 3'b101);
        oob     = idx >= 30'(DEPTH_WORDS);
`ifdef DMEM_MISALIGN_ERR_EN
        misalign = ((a_size[1:0] == 2'b01) && a_addr[0]) ||
                   ((a_size[1:0] == 2'b10) && (a_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        acc_err = (a_wr && a_rd) || oob || !size_ok || (a_wr && a_size[2]) || misalign;
        be = 4'b1111;
        wd = a_wdata;
        ld = word;
        case (a_size[1:0])
            2'b00: begin
                be = 4'b0001 << a_addr[1:0];
                wd = {4{a_wdata[7:0]}};
                case (a_addr[1:0])
                    2'b00:   ld = {24'd0, word[7:0]};
                    2'b01:   ld = {24'd0, word[15:8]};
                    2'b10:   ld = {24'd0, word[23:16]};
                    default: ld = {24'd0, word[31:24]};
                endcase
            end
            2'b01: begin
                be = a_addr[1] ? 4'b1100 : 4'b0011;
                wd = {2{a_wdata[15:0]}};
                ld = {16'd0, a_addr[1] ? word[31:16] : word[15:0]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            size_q  <= 3'd0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
        end else if (hs) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            size_q  <= size;
            wr_q    <= wr_en;
            rd_q    <= rd_en;
        end
    end

    // Reset has priority over the edge entering RESP, so an aborted store never commits.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'd0;
        end else if (enter_resp) begin
            err_q   <= acc_err;
            rdata_q <= (acc_err || a_wr) ? 32'd0 : ld;
            if (!acc_err && a_wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) mem[idx[AW-1:0]][8*b +: 8] <= wd[8*b +: 8];
                end
            end
        end else begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end
    end

    assign rdata   = rdata_q;
    assign rsp_err = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int WC    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, wr_en, rd_en;
    logic [31:0] addr, wdata, rdata;
    logic [2:0]  size;
    logic        rsp_valid, rsp_err, busy;

    int checks = 0;
    int errors = 0;
    byte unsigned mem_b [DEPTH*4];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata), .size(size),
        .rsp_valid(rsp_valid), .rdata(rdata), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < DEPTH*4; i++) mem_b[i] = 8'd0;
    endfunction

    // Byte-array memory: a request touches nb bytes starting at the size-aligned address.
    function automatic void model(input bit w, input bit r, input logic [31:0] a,
                                  input logic [31:0] d, input logic [2:0] s,
                                  output bit err, output logic [31:0] rd);
        int nb;
        int unsigned base;
        nb  = (s[1:0] == 2'd0) ? 1 : (s[1:0] == 2'd1) ? 2 : 4;
        err = (w && r) || ((a / 4) >= DEPTH) || !(s inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ||
              (w && s >= 3'd4);
`ifdef DMEM_MISALIGN_ERR_EN
        if ((a % nb) != 0) err = 1'b1;
`endif
        rd = 32'd0;
        if (!err) begin
            base = a - (a % nb);
            for (int i = 0; i < nb; i++) begin
                if (w) mem_b[base + i] = d[8*i +: 8];
                else   rd |= 32'(mem_b[base + i]) << (8*i);
            end
        end
    endfunction

    task automatic drive_junk();
        req_valid = 1'b0;
        wr_en = 1'($urandom); rd_en = 1'($urandom);
        addr = $urandom; wdata = $urandom; size = 3'($urandom);
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle after the response.
    task automatic do_req(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] s, output logic [31:0] rd_got, output logic err_got);
        bit          eerr;
        logic [31:0] erd;
        int          n;
        chk("ready", req_ready, 1);
        req_valid = 1'b1; wr_en = w; rd_en = r; addr = a; wdata = d; size = s;
        model(w, r, a, d, s, eerr, erd);
        @(negedge clk);
        drive_junk();
        chk("busy", busy, 1);
        n = 1;
        while (!rsp_valid && n <= 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, WC + 1);
        chk("rsp_err", rsp_err, eerr);
        chk("rdata", rdata, erd);
        rd_got  = rdata;
        err_got = rsp_err;
        @(negedge clk);
        chk("pulse", rsp_valid, 0);
    endtask

    task automatic reset_abort(input int delay);
        int seen;
        chk("ready_ra", req_ready, 1);
        req_valid = 1'b1; wr_en = 1'b1; rd_en = 1'b0;
        addr = 32'h20; wdata = 32'h12345678; size = 3'b010;
        @(negedge clk);
        drive_junk();
        repeat (delay - 1) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("abort_no_rsp", seen, 0);
    endtask

    logic [31:0] g_rd;
    logic        g_err;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        addr = 32'd0; wdata = 32'd0; size = 3'd0;
        model_clear();
        repeat (2) begin
            @(negedge clk);
            chk("rst_ready", req_ready, 0);
            chk("rst_valid", rsp_valid, 0);
            chk("rst_err", rsp_err, 0);
            chk("rst_rdata", rdata, 0);
            chk("rst_busy", busy, 0);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("idle_ready", req_ready, 1);

        do_req(1, 0, 32'h10, 32'hDEADBEEF, 3'b010, g_rd, g_err);
        chk("sw_err", g_err, 0);
        do_req(0, 1, 32'h10, 32'h0, 3'b010, g_rd, g_err);
        chk("lw_data", g_rd, 32'hDEADBEEF);

        do_req(1, 0, 32'h10, 32'h11223344, 3'b010, g_rd, g_err);
        do_req(1, 0, 32'h13, 32'hFFFFFFAA, 3'b000, g_rd, g_err);
        do_req(0, 1, 32'h13, 32'h0, 3'b100, g_rd, g_err);
        chk("lbu", g_rd, 32'h000000AA);
        do_req(0, 1, 32'h12, 32'h0, 3'b101, g_rd, g_err);
        chk("lhu", g_rd, 32'h0000AA22);
        do_req(0, 1, 32'h10, 32'h0, 3'b010, g_rd, g_err);
        chk("lw_merge", g_rd, 32'hAA223344);

        do_req(0, 1, DEPTH * 4, 32'h0, 3'b010, g_rd, g_err);
        chk("oob_err", g_err, 1);
        chk("oob_data", g_rd, 0);
        do_req(1, 1, 32'h10, 32'h55555555, 3'b010, g_rd, g_err);
        chk("both_err", g_err, 1);
        do_req(0, 1, 32'h10, 32'h0, 3'b010, g_rd, g_err);
        chk("both_nowrite", g_rd, 32'hAA223344);

        reset_abort(1);
        do_req(0, 1, 32'h20, 32'h0, 3'b010, g_rd, g_err);
        chk("abort_wait", g_rd, 0);
        reset_abort(WC);
        do_req(0, 1, 32'h20, 32'h0, 3'b010, g_rd, g_err);
        chk("abort_edge", g_rd, 0);

        do_req(1, 0, 32'h20, 32'hCAFEBABE, 3'b010, g_rd, g_err);
        do_req(0, 1, 32'h21, 32'h0, 3'b001, g_rd, g_err);
`ifdef DMEM_MISALIGN_ERR_EN
        chk("lh_mis_err", g_err, 1);
        chk("lh_mis_data", g_rd, 0);
`else
        chk("lh_mis_err", g_err, 0);
        chk("lh_mis_data", g_rd, 32'h0000BABE);
`endif

        for (int it = 0; it < 200; it++) begin
            int          kind;
            bit          w, r;
            logic [31:0] a;
            logic [2:0]  s;
            kind = $urandom_range(0, 19);
            if (kind == 0) begin
                req_valid = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
                addr = $urandom_range(0, 63); size = 3'b010;
                @(negedge clk);
                drive_junk();
                chk("noop_busy", busy, 0);
            end else begin
                w = (kind < 10);
                r = !w || (kind == 19);
                a = ($urandom_range(0, 9) == 0) ? 32'(DEPTH * 4) + $urandom_range(0, 4095)
                                                : 32'($urandom_range(0, 63));
                case ($urandom_range(0, 6))
                    0: s = 3'b000;
                    1: s = 3'b001;
                    2: s = 3'b010;
                    3: s = 3'b100;
                    4: s = 3'b101;
                    5: s = 3'b010;
                    default: s = 3'($urandom);
                endcase
                do_req(w, r, a, $urandom, s, g_rd, g_err);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
